// File: rtl/bsmu_322_if.sv
// Handshake/data bundle between the 8-state ACS unit and the
// survivor-memory unit: decisions, path metrics and decoded output.
interface bsmu_322_if #(
  parameter int W = 8
);
  logic                ae;
  logic [7:0][1:0]     acs_Bx_in;
  logic [7:0][W-1:0]   acs_ppm_in;
  logic [1:0]          dec_out;
  logic                dec_valid;
  logic [2:0]          best_state;
  logic                fill_done;

  modport master (
    output ae, acs_Bx_in, acs_ppm_in,
    input  dec_out, dec_valid, best_state, fill_done
  );

  modport slave (
    input  ae, acs_Bx_in, acs_ppm_in,
    output dec_out, dec_valid, best_state, fill_done
  );
endinterface

// File: rtl/bsmu_322.sv
// Register-exchange survivor memory for the (3,2,2) Viterbi decoder.
// Ports: clock, reset (async high), bus (slave): ae, Bx/ppm in; dec_out,
// dec_valid, best_state, fill_done out.
module bsmu_322 #(
  parameter int W  = 8,
  parameter int TB = 15
) (
  input  logic        clock,
  input  logic        reset,
  bsmu_322_if.slave   bus
);
  localparam int CW = $clog2(TB + 1);
  localparam logic [CW-1:0] TBC  = CW'(TB);
  localparam logic [CW-1:0] TBM1 = CW'(TB - 1);

  logic [2*TB-1:0] r_path [8];
  logic [CW-1:0]   r_fill;
  logic [1:0]      r_dec;
  logic            r_valid;
  logic [2:0]      r_best;
  logic            r_done;

  logic [2:0]      w_best;
  logic [W-1:0]    w_min;
  logic [2:0]      w_pred [8];
  logic [2*TB-1:0] w_next [8];
  logic [2:0]      w_bpred;
  logic            w_last;

  // Minimum metric; strict '<' keeps the lowest index on ties.
  always_comb begin
    w_best = 3'd0;
    w_min  = bus.acs_ppm_in[0];
    for (int i = 1; i < 8; i++) begin
      if (bus.acs_ppm_in[i] < w_min) begin
        w_min  = bus.acs_ppm_in[i];
        w_best = 3'(i);
      end
    end
  end

  // Each state inherits its predecessor's survivor, shifted one
  // entry toward the oldest end, with its own input symbol on top.
  for (genvar n = 0; n < 8; n++) begin : g_st
    localparam logic [2:0] N = 3'(n);
    assign w_pred[n] = {N[0], bus.acs_Bx_in[n]};
    assign w_next[n] = {N[2:1], r_path[w_pred[n]][2*TB-1:2]};
  end

  // Oldest entry of the best state's updated survivor is entry 1
  // of its predecessor's current survivor.
  assign w_bpred = {w_best[0], bus.acs_Bx_in[w_best]};
  assign w_last  = (r_fill >= TBM1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) r_path[i] <= '0;
      r_fill  <= '0;
      r_dec   <= 2'b00;
      r_valid <= 1'b0;
      r_best  <= 3'd0;
      r_done  <= 1'b0;
    end else if (bus.ae) begin
      for (int i = 0; i < 8; i++) r_path[i] <= w_next[i];
      if (r_fill != TBC) r_fill <= r_fill + CW'(1);
      r_dec   <= r_path[w_bpred][3:2];
      r_valid <= w_last;
      r_best  <= w_best;
      r_done  <= w_last;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign bus.dec_out    = r_dec;
  assign bus.dec_valid  = r_valid;
  assign bus.best_state = r_best;
  assign bus.fill_done  = r_done;
endmodule

// File: tb/tb_bsmu_322.sv
// Self-checking bench for bsmu_322: scoreboard of expected symbols
// against encoder-driven, gapped, reset and random stimulus.
module tb_bsmu_322;
  localparam int TB = 15;
  localparam int W  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bsmu_322_if #(.W(W)) bus ();

  bsmu_322 #(.W(W), .TB(TB)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  int strb   = 0;

  logic [1:0]          q [$];
  logic [7:0][1:0]     bx;
  logic [7:0][W-1:0]   ppm;
  logic [2:0]          enc_s;
  logic [1:0]          m_path [8][TB];
  int                  m_fill;

  task automatic cyc(input logic a);
    @(negedge clk);
    bus.ae         = a;
    bus.acs_Bx_in  = bx;
    bus.acs_ppm_in = ppm;
    @(posedge clk);
    #1;
    if (a) strb++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.ae = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    strb = 0;
    q.delete();
    enc_s = 3'd0;
    m_fill = 0;
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < TB; k++) m_path[i][k] = 2'b00;
  endtask

  // Drive decisions/metrics for a correctly tracking ACS unit.
  task automatic enc_setup(input logic [1:0] u);
    logic [2:0] n;
    n = {u, enc_s[2]};
    for (int i = 0; i < 8; i++) begin
      bx[i]  = 2'b00;
      ppm[i] = 8'd10;
    end
    bx[n]  = enc_s[1:0];
    ppm[n] = '0;
    enc_s  = n;
    q.push_back(u);
  endtask

  task automatic test_reset();
    bus.ae = 1'b0;
    bx  = '0;
    ppm = '0;
    bus.acs_Bx_in  = bx;
    bus.acs_ppm_in = ppm;
    repeat (2) @(negedge clk);
    n_tot++;
    if ({bus.dec_out, bus.dec_valid, bus.best_state, bus.fill_done} !== 7'b0)
      $display("FAIL reset_outs got %b exp 0",
        {bus.dec_out, bus.dec_valid, bus.best_state, bus.fill_done});
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_all_zero();
    logic ev;
    logic [1:0] e;
    int pulses;
    pulses = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bx[i]  = 2'b00;
      ppm[i] = (i == 0) ? 8'd0 : 8'd10;
    end
    for (int c = 0; c < 40; c++) begin
      q.push_back(2'b00);
      cyc(1'b1);
      ev = (strb >= TB);
      n_tot++;
      if (bus.dec_valid !== ev)
        $display("FAIL t1_valid strobe %0d got %b exp %b", strb, bus.dec_valid, ev);
      else n_pass++;
      n_tot++;
      if (bus.fill_done !== ev)
        $display("FAIL t1_fill strobe %0d got %b exp %b", strb, bus.fill_done, ev);
      else n_pass++;
      n_tot++;
      if (bus.best_state !== 3'd0)
        $display("FAIL t1_best got %0d exp 0", bus.best_state);
      else n_pass++;
      if (bus.dec_valid) begin
        pulses++;
        n_tot++;
        if (q.size() == 0)
          $display("FAIL t1_sb got %b exp none", bus.dec_out);
        else begin
          e = q.pop_front();
          if (bus.dec_out !== e)
            $display("FAIL t1_dec got %b exp %b", bus.dec_out, e);
          else n_pass++;
        end
      end
    end
    n_tot++;
    if (pulses != 26) $display("FAIL t1_pulses got %0d exp 26", pulses);
    else n_pass++;
  endtask

  task automatic test_encoder();
    logic ev;
    logic [1:0] e;
    logic [1:0] u;
    int pulses;
    pulses = 0;
    do_reset();
    for (int c = 0; c < 48; c++) begin
      case (c)
        0: u = 2'b11;
        1: u = 2'b01;
        2: u = 2'b10;
        3: u = 2'b00;
        default: u = 2'($urandom_range(0, 3));
      endcase
      enc_setup(u);
      cyc(1'b1);
      ev = (strb >= TB);
      n_tot++;
      if (bus.best_state !== enc_s)
        $display("FAIL t2_best got %0d exp %0d", bus.best_state, enc_s);
      else n_pass++;
      n_tot++;
      if (bus.dec_valid !== ev)
        $display("FAIL t2_valid strobe %0d got %b exp %b", strb, bus.dec_valid, ev);
      else n_pass++;
      if (bus.dec_valid) begin
        pulses++;
        n_tot++;
        if (q.size() == 0)
          $display("FAIL t2_sb got %b exp none", bus.dec_out);
        else begin
          e = q.pop_front();
          if (bus.dec_out !== e)
            $display("FAIL t2_dec strobe %0d got %b exp %b", strb, bus.dec_out, e);
          else n_pass++;
        end
      end
    end
    n_tot++;
    if (pulses != 48 - TB + 1)
      $display("FAIL t2_pulses got %0d exp %0d", pulses, 48 - TB + 1);
    else n_pass++;
  endtask

  task automatic test_tie();
    logic [2:0] eb;
    do_reset();
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 8; i++) bx[i] = 2'(i);
      case (t)
        0: begin ppm = {8{8'd20}};  eb = 3'd0; end
        1: begin ppm = {8{8'd5}};   ppm[5] = 8'd3; eb = 3'd5; end
        2: begin ppm = {8{8'd7}};   ppm[3] = 8'd2; ppm[6] = 8'd2; eb = 3'd3; end
        3: begin ppm = {8{8'd9}};   ppm[7] = 8'd0; eb = 3'd7; end
        default: begin ppm = {8{8'd255}}; ppm[2] = 8'd254; eb = 3'd2; end
      endcase
      cyc(1'b1);
      n_tot++;
      if (bus.best_state !== eb)
        $display("FAIL t3_best case %0d got %0d exp %0d", t, bus.best_state, eb);
      else n_pass++;
    end
  endtask

  task automatic test_gaps();
    logic [1:0] e;
    logic [2:0] hold;
    int pulses;
    pulses = 0;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      enc_setup(2'($urandom_range(0, 3)));
      cyc(1'b1);
      n_tot++;
      if (bus.dec_valid !== (strb >= TB))
        $display("FAIL t4_valid strobe %0d got %b exp %b", strb, bus.dec_valid, strb >= TB);
      else n_pass++;
      if (bus.dec_valid) begin
        pulses++;
        n_tot++;
        if (q.size() == 0)
          $display("FAIL t4_sb got %b exp none", bus.dec_out);
        else begin
          e = q.pop_front();
          if (bus.dec_out !== e)
            $display("FAIL t4_dec strobe %0d got %b exp %b", strb, bus.dec_out, e);
          else n_pass++;
        end
      end
      hold = enc_s;
      for (int g = 0; g < 2; g++) begin
        for (int i = 0; i < 8; i++) begin
          bx[i]  = 2'($urandom_range(0, 3));
          ppm[i] = 8'($urandom_range(0, 255));
        end
        cyc(1'b0);
        n_tot++;
        if (bus.dec_valid !== 1'b0 || bus.best_state !== hold)
          $display("FAIL t4_gap got v=%b b=%0d exp v=0 b=%0d",
            bus.dec_valid, bus.best_state, hold);
        else n_pass++;
      end
    end
    n_tot++;
    if (pulses != 30 - TB + 1)
      $display("FAIL t4_pulses got %0d exp %0d", pulses, 30 - TB + 1);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    logic [1:0] e;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      enc_setup(2'b11);
      cyc(1'b1);
      n_tot++;
      if (bus.dec_valid !== 1'b0 || bus.fill_done !== 1'b0)
        $display("FAIL t5_pre got v=%b f=%b exp 0 0", bus.dec_valid, bus.fill_done);
      else n_pass++;
    end
    #2;
    rst = 1'b1;
    #1;
    n_tot++;
    if ({bus.best_state, bus.fill_done, bus.dec_valid} !== 5'b0)
      $display("FAIL t5_async got b=%0d f=%b v=%b exp 0",
        bus.best_state, bus.fill_done, bus.dec_valid);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      bx[i]  = 2'($urandom_range(0, 3));
      ppm[i] = (i == 6) ? 8'd0 : 8'd40;
    end
    bus.ae = 1'b1;
    bus.acs_Bx_in  = bx;
    bus.acs_ppm_in = ppm;
    repeat (2) @(posedge clk);
    #1;
    n_tot++;
    if (bus.best_state !== 3'd0 || bus.fill_done !== 1'b0)
      $display("FAIL t5_rst_wins got b=%0d f=%b exp 0 0", bus.best_state, bus.fill_done);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    bus.ae = 1'b0;
    strb = 0;
    q.delete();
    enc_s = 3'd0;
    for (int c = 0; c < TB; c++) begin
      enc_setup(2'($urandom_range(0, 3)));
      cyc(1'b1);
      n_tot++;
      if (bus.dec_valid !== (strb == TB) || bus.fill_done !== (strb == TB))
        $display("FAIL t5_post strobe %0d got v=%b f=%b exp %b",
          strb, bus.dec_valid, bus.fill_done, strb == TB);
      else n_pass++;
      if (bus.dec_valid) begin
        n_tot++;
        e = q.pop_front();
        if (bus.dec_out !== e)
          $display("FAIL t5_dec got %b exp %b", bus.dec_out, e);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] nw [8][TB];
    logic [1:0] e;
    logic [2:0] nn;
    logic [2:0] p;
    logic [2:0] mb;
    logic a;
    logic ev;
    int stages;
    stages = 0;
    mb = 3'd0;
    do_reset();
    while (stages < 1000) begin
      a = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 8; i++) begin
        bx[i]  = 2'($urandom_range(0, 3));
        ppm[i] = 8'($urandom_range(0, 15));
      end
      ev = 1'b0;
      if (a) begin
        stages++;
        mb = 3'd0;
        for (int i = 1; i < 8; i++)
          if (ppm[i] < ppm[mb]) mb = 3'(i);
        for (int n = 0; n < 8; n++) begin
          nn = 3'(n);
          p  = {nn[0], bx[n]};
          nw[n][TB-1] = nn[2:1];
          for (int k = 0; k < TB - 1; k++) nw[n][k] = m_path[p][k+1];
        end
        m_path = nw;
        if (m_fill >= TB - 1) begin
          ev = 1'b1;
          q.push_back(nw[mb][0]);
        end
        if (m_fill < TB) m_fill++;
      end
      cyc(a);
      n_tot++;
      if (bus.dec_valid !== ev || bus.best_state !== mb ||
          bus.fill_done !== (m_fill == TB))
        $display("FAIL t6_ctl stage %0d got v=%b b=%0d f=%b exp v=%b b=%0d f=%b",
          stages, bus.dec_valid, bus.best_state, bus.fill_done,
          ev, mb, m_fill == TB);
      else n_pass++;
      if (bus.dec_valid) begin
        n_tot++;
        if (q.size() == 0)
          $display("FAIL t6_sb got %b exp none", bus.dec_out);
        else begin
          e = q.pop_front();
          if (bus.dec_out !== e)
            $display("FAIL t6_dec stage %0d got %b exp %b", stages, bus.dec_out, e);
          else n_pass++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_encoder();
    test_tie();
    test_gaps();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
